sub32_operand_sequencer: RTL



---
 rtl/sub32_pkg.sv | 15 +
 rtl/binary_subtractor_32_bit.sv | 20 ++
 rtl/sub32_operand_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/sub32_pkg.sv
// Shared constants and state encoding for the 32-bit subtract operand sequencer.
package sub32_pkg;

    localparam int DATA_W = 32;
    localparam int BYTE_W = 8;
    localparam int NBYTES = DATA_W / BYTE_W;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/binary_subtractor_32_bit.sv
// Combinational two's-complement subtractor: s = a + ~b + cin, cout = carry out.
module binary_subtractor_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);

    logic [32:0] w_sum;

    // Full 33-bit add of a and inverted b; carry out is the no-borrow indication.
    always_comb begin
        w_sum = {1'b0, a} + {1'b0, ~b} + {32'd0, cin};
    end

    assign s    = w_sum[31:0];
    assign cout = w_sum[32];

endmodule

// File: rtl/sub32_operand_sequencer.sv
// Byte-stream operand assembler and result collector for binary_subtractor_32_bit.
// Loads A then B LSB-first, holds them on a_out/b_out, captures s/cout after one
// settle cycle and presents the registered difference and flags on a valid/ready port.
module sub32_operand_sequencer
    import sub32_pkg::*;
#(
    parameter int DATA_W = sub32_pkg::DATA_W,
    parameter int BYTE_W = sub32_pkg::BYTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_byte,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              cin_out,
    input  logic [DATA_W-1:0] s_in,
    input  logic              cout_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_borrow,
    output logic              res_zero,
    output logic              res_neg,
    output logic              res_ovf
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_res_valid;
    logic [DATA_W-1:0]   r_res_data;
    logic                r_res_borrow;
    logic                r_res_zero;
    logic                r_res_neg;
    logic                r_res_ovf;

    logic                w_take;
    logic                w_last;

    assign in_ready = (r_state == LOAD_A) || (r_state == LOAD_B);
    assign w_take   = in_valid && in_ready;
    assign w_last   = (r_cnt == CNT_W'(NB - 1));

    // Sequencer FSM: operand byte loading, result capture and result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= LOAD_A;
            r_cnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_borrow <= 1'b0;
            r_res_zero   <= 1'b0;
            r_res_neg    <= 1'b0;
            r_res_ovf    <= 1'b0;
        end else if (clr) begin
            // Abort: operands are kept on a_out/b_out, any pending result is dropped.
            r_state     <= LOAD_A;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                LOAD_A: begin
                    if (w_take) begin
                        r_a[r_cnt*BYTE_W +: BYTE_W] <= in_byte;
                        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                        if (w_last) r_state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (w_take) begin
                        r_b[r_cnt*BYTE_W +: BYTE_W] <= in_byte;
                        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                        if (w_last) r_state <= EXEC;
                    end
                end
                EXEC: begin
                    // Subtractor has had a full cycle to settle on the held operands.
                    r_res_data   <= s_in;
                    r_res_borrow <= ~cout_in;
                    r_res_zero   <= (s_in == '0);
                    r_res_neg    <= s_in[DATA_W-1];
                    r_res_ovf    <= (r_a[DATA_W-1] != r_b[DATA_W-1]) &&
                                    (s_in[DATA_W-1] != r_a[DATA_W-1]);
                    r_res_valid  <= 1'b1;
                    r_state      <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= LOAD_A;
                    end
                end
                default: r_state <= LOAD_A;
            endcase
        end
    end

    assign a_out      = r_a;
    assign b_out      = r_b;
    assign cin_out    = 1'b1;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_borrow = r_res_borrow;
    assign res_zero   = r_res_zero;
    assign res_neg    = r_res_neg;
    assign res_ovf    = r_res_ovf;

endmodule
